// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch and data ports.
// Define ARB_PERF_CNT_EN to add the perf_if_wait / perf_d_wait request-wait counters.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_if_wait,
  output logic [31:0] perf_d_wait
`endif
);

  // Handshake: a requester raises *_req with its command stable and keeps it so
  // until the one-cycle *_ack; requests are only looked at while the FSM is IDLE,
  // so the cycle after an ack is free for the requester to drop or replace it.

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  state_t         state;
  owner_t         owner;
  logic [CW-1:0]  waitCnt;
  logic [SW-1:0]  streak;
  logic           streakFull;

  assign streakFull = (streak == SW'(MAX_D_STREAK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      waitCnt   <= '0;
      streak    <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_req) streak <= '0;
          // Data has priority unless the fetch port has waited out a full streak.
          if (d_req && !(if_req && streakFull)) begin
            owner     <= OWN_D;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
            if (if_req) streak <= streak + 1'b1;
          end else if (if_req) begin
            owner     <= OWN_IF;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_en    <= 1'b1;
            streak    <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          waitCnt <= CW'(MEM_LATENCY);
          state   <= WAIT;
        end
        WAIT: begin
          if (waitCnt == CW'(1)) begin
            state <= RESP;
            if (owner == OWN_D) begin
              d_rdata <= mem_we ? 32'd0 : mem_rdata;
              d_ack   <= 1'b1;
            end else if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        RESP: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_wait <= '0;
      perf_d_wait  <= '0;
    end else begin
      if (if_req && !if_ack && (perf_if_wait != '1)) perf_if_wait <= perf_if_wait + 1'b1;
      if (d_req && !d_ack && (perf_d_wait != '1)) perf_d_wait <= perf_d_wait + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level arbitration/memory model.
module tb_mem_port_arbiter;
  localparam int MEM_LATENCY  = 2;
  localparam int MAX_D_STREAK = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_d_wait;
`endif

  mem_port_arbiter #(.MEM_LATENCY(MEM_LATENCY), .MAX_D_STREAK(MAX_D_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_default(input logic [31:0] a);
    if (a == 32'h10) return 32'h0010_0093;
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
  endfunction

  // Environment memory: answers MEM_LATENCY cycles after the mem_en cycle, garbage otherwise.
  typedef struct { int due; logic [31:0] data; } rd_t;
  rd_t rd_q[$];
  logic [31:0] mem_arr[logic [31:0]];
  int mcyc = 0;

  always @(posedge clk) begin : memory
    rd_t r;
    mcyc++;
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        mem_arr[mem_addr] = mem_wdata;
        r.data = $urandom;
      end else begin
        r.data = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : mem_default(mem_addr);
      end
      r.due = mcyc + MEM_LATENCY - 1;
      rd_q.push_back(r);
    end
    #1;
    while (rd_q.size() > 0 && rd_q[0].due < mcyc) void'(rd_q.pop_front());
    mem_rdata = $urandom;
    if (rd_q.size() > 0 && rd_q[0].due == mcyc) begin
      mem_rdata = rd_q[0].data;
      void'(rd_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  // One access at a time: grant at edge g, mem_en visible after g, ack after g+L+1,
  // next sampling edge g+L+3. Data wins unless fetch has lost MAX_D_STREAK in a row.
  typedef struct {
    bit          is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
  } txn_t;
  txn_t exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  int cyc       = 0;
  int next_free = 0;
  int streak_m  = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  always @(posedge clk) begin : model
    txn_t t;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].g + MEM_LATENCY + 1 < cyc) void'(exp_q.pop_front());
    if (rst === 1'b1) begin
      exp_q.delete();
      streak_m  = 0;
      next_free = cyc + 1;
    end else if (cyc >= next_free) begin
      if (d_req && !(if_req && streak_m == MAX_D_STREAK)) begin
        t.is_d = 1'b1; t.we = d_we; t.addr = d_addr; t.wdata = d_wdata; t.g = cyc;
        if (d_we) begin
          ref_mem[d_addr] = d_wdata;
          t.rdata = 32'd0;
        end else begin
          t.rdata = ref_read(d_addr);
        end
        exp_q.push_back(t);
        next_free = cyc + MEM_LATENCY + 3;
        streak_m  = if_req ? streak_m + 1 : 0;
      end else if (if_req) begin
        t.is_d = 1'b0; t.we = 1'b0; t.addr = if_addr; t.wdata = 32'd0; t.g = cyc;
        t.rdata = ref_read(if_addr);
        exp_q.push_back(t);
        next_free = cyc + MEM_LATENCY + 3;
        streak_m  = 0;
      end else begin
        streak_m = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;

  always @(negedge clk) begin : chk
    logic exp_en, exp_ia, exp_da;
    if (rst !== 1'b0) begin
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
    end else begin
      exp_en = 1'b0; exp_ia = 1'b0; exp_da = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i].g == cyc) begin
          exp_en = 1'b1;
          check32("mem_we", 32'(mem_we), 32'(exp_q[i].we));
          check32("mem_addr", mem_addr, exp_q[i].addr);
          check32("mem_wdata", mem_wdata, exp_q[i].wdata);
        end
        if (exp_q[i].g + MEM_LATENCY + 1 == cyc) begin
          if (exp_q[i].is_d) begin
            exp_da = 1'b1;
            exp_d_rdata = exp_q[i].rdata;
          end else begin
            exp_ia = 1'b1;
            exp_if_rdata = exp_q[i].rdata;
          end
        end
      end
      check32("mem_en", 32'(mem_en), 32'(exp_en));
      check32("if_ack", 32'(if_ack), 32'(exp_ia));
      check32("d_ack", 32'(d_ack), 32'(exp_da));
      check32("if_rdata", if_rdata, exp_if_rdata);
      check32("d_rdata", d_rdata, exp_d_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic if_access(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    if_req = 1'b1; if_addr = addr; lat = 0; rdata = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (if_ack === 1'b1) begin lat = i; rdata = if_rdata; break; end
    end
    if_req = 1'b0;
    if (lat == 0) begin
      checks++; failures++;
      $error("FAIL if_timeout: observed=no ack expected=ack within 200 cycles");
    end
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; lat = 0; rdata = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (d_ack === 1'b1) begin lat = i; rdata = d_rdata; break; end
    end
    d_req = 1'b0;
    if (lat == 0) begin
      checks++; failures++;
      $error("FAIL d_timeout: observed=no ack expected=ack within 200 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    #1;
    check32("rst_if_ack", 32'(if_ack), 32'd0);
    check32("rst_d_ack", 32'(d_ack), 32'd0);
    check32("rst_mem_en", 32'(mem_en), 32'd0);
    check32("rst_mem_we", 32'(mem_we), 32'd0);
    check32("rst_if_rdata", if_rdata, 32'd0);
    check32("rst_d_rdata", d_rdata, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] rd_if, rd_d;
  int lat_if, lat_d, cyc_if, cyc_d, d_done, d_done_at_if;

  initial begin
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    do_reset();

    // single fetch
    if_access(32'h10, rd_if, lat_if);
    check32("fetch_latency", 32'(lat_if), 32'(MEM_LATENCY + 2));
    check32("fetch_rdata", rd_if, 32'h0010_0093);
    repeat (2) @(negedge clk);

    // simultaneous requests: data first, fetch granted the IDLE cycle after d_ack
    do_reset();
    fork
      begin d_access(1'b0, 32'h80, 32'h0, rd_d, lat_d); cyc_d = cyc; end
      begin
        if_access(32'h20, rd_if, lat_if); cyc_if = cyc;
`ifdef ARB_PERF_CNT_EN
        check32("perf_d_wait", perf_d_wait, 32'(MEM_LATENCY + 2));
        check32("perf_if_wait", perf_if_wait, 32'(2 * MEM_LATENCY + 5));
`endif
      end
    join
    check32("simul_d_latency", 32'(lat_d), 32'(MEM_LATENCY + 2));
    check32("simul_if_after_d", 32'(cyc_if - cyc_d), 32'(MEM_LATENCY + 3));
    check32("simul_d_rdata", rd_d, mem_default(32'h80));
    repeat (2) @(negedge clk);

    // store then load back
    d_access(1'b1, 32'h40, 32'hDEAD_BEEF, rd_d, lat_d);
    check32("store_rdata", rd_d, 32'd0);
    check32("store_latency", 32'(lat_d), 32'(MEM_LATENCY + 2));
    d_access(1'b0, 32'h40, 32'h0, rd_d, lat_d);
    check32("load_back", rd_d, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);

    // starvation guard: fetch slips in after exactly MAX_D_STREAK data grants
    d_done = 0;
    fork
      begin if_access(32'h100, rd_if, lat_if); d_done_at_if = d_done; end
      begin
        for (int k = 0; k < MAX_D_STREAK + 2; k++) begin
          d_access(1'b0, 32'h200 + 32'(4 * k), 32'h0, rd_d, lat_d);
          d_done++;
        end
      end
    join
    check32("streak_d_before_if", 32'(d_done_at_if), 32'(MAX_D_STREAK));
    check32("streak_d_total", 32'(d_done), 32'(MAX_D_STREAK + 2));
    repeat (2) @(negedge clk);

    // reset while waiting on memory: aborted access never acks
    if_req = 1'b1; if_addr = 32'h30;
    repeat (3) @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);
    if_access(32'h10, rd_if, lat_if);
    check32("post_rst_latency", 32'(lat_if), 32'(MEM_LATENCY + 2));
    check32("post_rst_rdata", rd_if, 32'h0010_0093);

    // randomized contention
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if_access(32'h40 + 32'(4 * $urandom_range(0, 7)), rd_if, lat_if);
        end
      end
      begin
        for (int k = 0; k < 16; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          d_access(1'($urandom_range(0, 1)), 32'h40 + 32'(4 * $urandom_range(0, 7)),
                   $urandom, rd_d, lat_d);
        end
      end
    join
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one fixed-latency, single-port unified memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage load/store) port.
- Replaces the separate instruction/data memory arrays.
- Services one access at a time through a 4-state FSM.
- Data port has priority; a streak counter prevents fetch starvation.

Parameters:
- MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range >= 1.
- MAX_D_STREAK, 4, maximum consecutive data grants while if_req is pending; legal range >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load data; 0 after a store.
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  32  byte address passed unchanged, valid with mem_en.
- mem_wdata  out  32  write data, valid with mem_en.
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after the mem_en cycle.

Behaviour:
- Reset (async, immediate): state IDLE.
  - if_ack, d_ack, mem_en, mem_we = 0.
  - if_rdata, d_rdata, mem_addr, mem_wdata = 0.
  - Streak counter = 0; owner = none.
  - Any in-flight memory response is discarded and no ack is produced.
- All outputs are registered (Moore).
- IDLE: requests are sampled only in this state.
  - Winner selection:
    - If d_req and not (if_req and streak == MAX_D_STREAK): the data port wins.
    - Else if if_req: the IF port wins.
    - Else: remain in IDLE.
  - On a grant: latch owner, addr, we and wdata (IF port: we = 0, wdata = 0), then go to ISSUE.
- Streak counter:
  - +1 on a data grant while if_req is high (saturates at MAX_D_STREAK).
  - Cleared on an IF grant, and on any IDLE cycle with if_req low.
- ISSUE: mem_en = 1 with the latched mem_we/mem_addr/mem_wdata; load the wait counter with MEM_LATENCY; go to WAIT.
- WAIT: decrement the counter each cycle.
  - In the cycle MEM_LATENCY after ISSUE, capture mem_rdata into the owner's rdata register (d_rdata = 0 for stores).
  - Then go to RESP.
- RESP: assert the owner's ack for exactly one cycle; the other port's ack stays 0; go to IDLE.
  - Requests are ignored in RESP. The requester may drop or replace its request in the cycle after ack.
- Timing (request held high before edge E0 while in IDLE):
  - mem_en in cycle E0+1.
  - ack in cycle E0+MEM_LATENCY+2.
  - The next grant is sampled at the end of cycle E0+MEM_LATENCY+3.
- Boundary conditions:
  - The non-owner's rdata register holds its previous value.
  - A request dropped before ack is a protocol violation; behaviour is undefined, but the FSM must still return to IDLE.
  - Both requests arriving together resolve per the priority rule; the loser stays pending, with no loss.
  - rst asserted in any state behaves as Reset above; the first request after rst release follows the Timing rule.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds outputs perf_if_wait[31:0] and perf_d_wait[31:0] (both reset to 0):
  - perf_if_wait: +1 each cycle if_req = 1 and if_ack = 0.
  - perf_d_wait: +1 each cycle d_req = 1 and d_ack = 0.
  - Both saturate at 0xFFFFFFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single fetch: MEM_LATENCY=2, if_req with if_addr=0x10 at E0=0, memory returns 0x00100093 → mem_en=1 in cycle 1 only with mem_addr=0x10, mem_we=0; if_ack=1 in cycle 4 only with if_rdata=0x00100093; d_ack stays 0.
- Simultaneous requests: if_req (0x20) and d_req load (0x80) at the same edge → data access issued first; d_ack, then IF mem_en 2 cycles after d_ack, then if_ack.
- Starvation: MAX_D_STREAK=4, d_req held continuously (new load after each ack) with if_req held → exactly 4 data grants, then 1 IF grant, then data resumes.
- Store: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → mem_en cycle shows mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF; d_ack pulses with d_rdata=0.
- Reset mid-access: rst pulsed during WAIT → all outputs 0 immediately, no ack for the aborted access; a fresh if_req afterwards completes with the nominal MEM_LATENCY+2 timing.
- ARB_PERF_CNT_EN build: repeat the simultaneous-request scenario with MEM_LATENCY=2 → after if_ack, perf_d_wait=4 and perf_if_wait=9.
